regfile_dump_ctrl: RTL and testbench

- Debug-side controller that shares read port 1 of the register bank between the pipeline and the debug unit.
- On a start pulse it takes over the read address, walks all 2**NB_ADDR registers, and streams each word as bytes over a valid/ready byte interface. That interface feeds the UART TX path.
- When not dumping, it passes the pipeline read address straight through.
- The caller halts the pipeline before asserting i_start.

---
 rtl/regfile_dump_ctrl_pkg.sv | 22 ++
 rtl/regfile_dump_ctrl.sv | 96 +++++++++
 tb/tb_regfile_dump_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_ctrl_pkg.sv
// Shared definitions for the debug dump controllers: FSM encoding and
// word-to-byte serialisation constants.
package regfile_dump_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } dump_state_e;

  localparam int NB_REGISTER_DEF = 32;
  localparam int NB_BYTE_DEF     = 8;
  localparam int BYTES_PER_WORD  = NB_REGISTER_DEF / NB_BYTE_DEF;
  localparam int BYTE_CNT_W      = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  // Counter width that can hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Borrows register bank read port 1 from the pipeline and streams every
// register out as little-endian bytes on a valid/ready byte interface.
module regfile_dump_ctrl
  import regfile_dump_ctrl_pkg::*;
#(
  parameter int NB_REGISTER = 32,
  parameter int NB_ADDR     = 5,
  parameter int NB_BYTE     = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [NB_ADDR-1:0]     i_pipe_r_addr,
  output logic [NB_ADDR-1:0]     o_r_addr,
  input  logic [NB_REGISTER-1:0] i_r_data,
  output logic [NB_BYTE-1:0]     o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready,
  output logic                   o_busy,
  output logic                   o_done,
  output dump_state_e            o_dbg_state
);

  localparam int BPW = NB_REGISTER / NB_BYTE;
  localparam int BCW = cnt_width(BPW);
  localparam logic [BCW-1:0]     LAST_BYTE = BCW'(BPW - 1);
  localparam logic [NB_ADDR-1:0] ADDR_MAX  = {NB_ADDR{1'b1}};

  dump_state_e            state_q, state_d;
  logic [NB_ADDR-1:0]     addr_q, addr_d;
  logic [BCW-1:0]         byte_q, byte_d;
  logic [NB_REGISTER-1:0] shift_q, shift_d;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      byte_q  <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
    end
  end

  // Byte handshake: a byte transfers on any cycle where o_tx_valid and
  // i_tx_ready are both high; o_tx_valid comes only from state and o_tx_data
  // holds until the transfer, so a stalled byte is never lost or repeated.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_LOAD;
          addr_d  = '0;
          byte_d  = '0;
        end
      end
      ST_LOAD: begin
        shift_d = i_r_data;
        byte_d  = '0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (i_tx_ready) begin
          shift_d = shift_q >> NB_BYTE;
          byte_d  = byte_q + 1'b1;
          if (byte_q == LAST_BYTE) begin
            byte_d = '0;
            if (addr_q == ADDR_MAX) begin
              state_d = ST_DONE;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = ST_LOAD;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_r_addr    = (state_q == ST_IDLE) ? i_pipe_r_addr : addr_q;
  assign o_tx_data   = shift_q[NB_BYTE-1:0];
  assign o_tx_valid  = (state_q == ST_SEND);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = (state_q == ST_DONE);
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Bench for regfile_dump_ctrl: idle passthrough vectors, full dumps with and
// without backpressure, start-while-busy, chained start and reset mid-dump.
module tb_regfile_dump_ctrl;

  localparam int NB_REGISTER = 32;
  localparam int NB_ADDR     = 5;
  localparam int NB_BYTE     = 8;
  localparam int NREGS       = 1 << NB_ADDR;
  localparam int NBYTES      = NREGS * (NB_REGISTER / NB_BYTE);

  logic                   clk;
  logic                   rst_n;
  logic                   start;
  logic [NB_ADDR-1:0]     pipe_addr;
  logic [NB_ADDR-1:0]     r_addr;
  logic [NB_REGISTER-1:0] r_data;
  logic [NB_BYTE-1:0]     tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
  logic                   busy;
  logic                   done;
  logic [1:0]             dbg_state;

  int checks = 0;
  int errors = 0;
  int bytes_seen = 0;
  logic [NB_BYTE-1:0] exp_q[$];

  regfile_dump_ctrl #(
    .NB_REGISTER(NB_REGISTER), .NB_ADDR(NB_ADDR), .NB_BYTE(NB_BYTE)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_start(start),
    .i_pipe_r_addr(pipe_addr), .o_r_addr(r_addr), .i_r_data(r_data),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .o_busy(busy), .o_done(done), .o_dbg_state(dbg_state)
  );

  // Register bank model: reg[k] = 0xA5000000 | k, read combinationally.
  assign r_data = 32'hA500_0000 | 32'(r_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_dump();
    logic [NB_REGISTER-1:0] w;
    for (int k = 0; k < NREGS; k++) begin
      w = 32'hA500_0000 | 32'(k);
      for (int b = 0; b < NB_REGISTER / NB_BYTE; b++) exp_q.push_back(w[b*NB_BYTE +: NB_BYTE]);
    end
  endtask

  // Output monitor: pops the scoreboard on every accepted byte and checks
  // that a stalled byte holds its value.
  logic               stall_prev = 1'b0;
  logic [NB_BYTE-1:0] data_prev  = '0;
  always @(negedge clk) begin
    if (tx_valid) begin
      if (stall_prev) check("stall_hold", 32'(tx_data), 32'(data_prev));
      if (tx_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_byte", 32'(bytes_seen), 32'(NBYTES));
        end else begin
          check("byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
        bytes_seen++;
      end
      stall_prev = !tx_ready;
      data_prev  = tx_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Cycle 1 is the cycle in which start is high; counts are relative to it.
  task automatic run_dump(input bit rnd, input int restart_at, input bit chain);
    int cyc, busy_n, done_n, first_v, done_cyc, exp_dones;
    bit prev_done, finished, restarted;
    exp_dones = chain ? 2 : 1;
    push_dump();
    bytes_seen = 0;
    cyc = 1; busy_n = 0; done_n = 0; first_v = 0; done_cyc = 0;
    prev_done = 1'b0; finished = 1'b0; restarted = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    pipe_addr = 5'd5;
    tx_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
    while (!finished && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (busy) busy_n++;
      if (tx_valid && first_v == 0) first_v = cyc;
      if (prev_done) begin
        check("addr_return", 32'(r_addr), 32'd5);
        check("busy_after_done", 32'(busy), 32'd0);
        if (done_n == exp_dones) finished = 1'b1;
        else start = 1'b1;
      end
      if (chain && done_n == 1 && cyc == done_cyc + 2) check("chain_restart", 32'(busy), 32'd1);
      if (busy && !done) check("addr_own", 32'(r_addr), 32'((bytes_seen % NBYTES) / 4));
      prev_done = done;
      if (done) begin
        done_n++;
        if (done_n == 1) done_cyc = cyc;
        if (chain && done_n == 1) begin
          start = 1'b1;
          push_dump();
        end
        pipe_addr = 5'd5;
      end else begin
        pipe_addr = cyc[0] ? 5'd5 : 5'd26;
      end
      if (restart_at >= 0 && !restarted && bytes_seen == restart_at && busy) begin
        start = 1'b1;
        restarted = 1'b1;
      end
      tx_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
    start = 1'b0;
    check("dump_finished", 32'(finished), 32'd1);
    check("done_count", 32'(done_n), 32'(exp_dones));
    check("byte_count", 32'(bytes_seen), 32'(NBYTES * exp_dones));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    if (!rnd) begin
      check("first_valid_cycle", 32'(first_v), 32'd3);
      check("done_cycle", 32'(done_cyc), 32'd162);
      check("busy_cycles", 32'(busy_n), 32'(161 * exp_dones));
    end
  endtask

  task automatic reset_mid();
    int cyc;
    push_dump();
    bytes_seen = 0;
    @(posedge clk); #1;
    start = 1'b1; tx_ready = 1'b1; pipe_addr = 5'd9;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (bytes_seen != 30 && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("reach_reg7_byte2", 32'(bytes_seen), 32'd30);
    check("pre_reset_valid", 32'(tx_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_valid_drop", 32'(tx_valid), 32'd0);
    check("rst_busy_drop", 32'(busy), 32'd0);
    check("rst_data_zero", 32'(tx_data), 32'd0);
    check("rst_addr_pass", 32'(r_addr), 32'd9);
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_done", 32'(done), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 32'(dbg_state), 32'd0);
  endtask

  typedef struct {
    logic               rst;
    logic [NB_ADDR-1:0] pipe;
    logic [NB_ADDR-1:0] exp_addr;
    logic               exp_busy;
    logic               exp_valid;
    logic               exp_done;
    logic [NB_BYTE-1:0] exp_data;
  } vec_t;

  vec_t vecs[34];

  initial begin
    rst_n = 1'b0; start = 1'b0; pipe_addr = '0; tx_ready = 1'b0;
    vecs[0] = '{1'b0, 5'd3,  5'd3,  1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 5'd30, 5'd30, 1'b0, 1'b0, 1'b0, 8'h00};
    for (int i = 0; i < 32; i++) vecs[i+2] = '{1'b1, 5'(i), 5'(i), 1'b0, 1'b0, 1'b0, 8'h00};

    for (int i = 0; i < 34; i++) begin
      @(posedge clk); #1;
      rst_n = vecs[i].rst;
      pipe_addr = vecs[i].pipe;
      #2;
      check("vec_addr",  32'(r_addr),   32'(vecs[i].exp_addr));
      check("vec_busy",  32'(busy),     32'(vecs[i].exp_busy));
      check("vec_valid", 32'(tx_valid), 32'(vecs[i].exp_valid));
      check("vec_done",  32'(done),     32'(vecs[i].exp_done));
      check("vec_data",  32'(tx_data),  32'(vecs[i].exp_data));
    end

    run_dump(1'b0, -1, 1'b0);
    run_dump(1'b1, -1, 1'b0);
    run_dump(1'b0, 50, 1'b0);
    run_dump(1'b0, -1, 1'b1);
    reset_mid();
    run_dump(1'b0, -1, 1'b0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
